// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin write controller for one shared register
// with true and complement outputs. A hold limit bounds each grant's tenure.
module shared_reg_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_HOLD   = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_in,
    input  logic [NUM_REQ-1:0]                wr_en_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     wr_data_in,
    output logic [NUM_REQ-1:0]                grant_out,
    output logic [$clog2(NUM_REQ)-1:0]        owner_out,
    output logic                              busy_out,
    output logic                              timeout_out,
    output logic [DATA_WIDTH-1:0]             Q_out,
    output logic [DATA_WIDTH-1:0]             Qb_out
);

    localparam int unsigned OWNER_W = $clog2(NUM_REQ);
    localparam int unsigned HOLD_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                  state_q,   state_d;
    logic [NUM_REQ-1:0]      grant_q,   grant_d;
    logic [OWNER_W-1:0]      owner_q,   owner_d;
    logic [OWNER_W-1:0]      ptr_q,     ptr_d;
    logic [HOLD_W-1:0]       hold_q,    hold_d;
    logic                    busy_q,    busy_d;
    logic                    timeout_q, timeout_d;
    logic [DATA_WIDTH-1:0]   q_q,       q_d;
    logic [DATA_WIDTH-1:0]   qb_q,      qb_d;

    logic                    found;
    logic [OWNER_W-1:0]      winner;
    logic [OWNER_W-1:0]      idx;
    logic [DATA_WIDTH-1:0]   owner_data;

    // First requester at or after the priority pointer, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        idx    = ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ptr_q + OWNER_W'(i);
            if (!found && req_in[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Data lane of the current owner.
    always_comb begin
        owner_data = wr_data_in[32'(owner_q) * DATA_WIDTH +: DATA_WIDTH];
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        q_d       = q_q;
        qb_d      = qb_q;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_GRANT;
                    grant_d = NUM_REQ'(1) << winner;
                    owner_d = winner;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                if (wr_en_in[owner_q]) begin
                    q_d  = owner_data;
                    qb_d = ~owner_data;
                end
                // A dropped request wins over a simultaneous hold expiry.
                if (!req_in[owner_q] || (hold_q == HOLD_W'(MAX_HOLD - 1))) begin
                    state_d   = ST_GAP;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    hold_d    = '0;
                    ptr_d     = owner_q + OWNER_W'(1);
                    timeout_d = req_in[owner_q];
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            q_q       <= '0;
            qb_q      <= '1;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            q_q       <= q_d;
            qb_q      <= qb_d;
        end
    end

    assign grant_out   = grant_q;
    assign owner_out   = owner_q;
    assign busy_out    = busy_q;
    assign timeout_out = timeout_q;
    assign Q_out       = q_q;
    assign Qb_out      = qb_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_shared_reg_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned MH  = 8;

    logic            clock;
    logic            reset;
    logic [N-1:0]    req_in;
    logic [N-1:0]    wr_en_in;
    logic [N*DW-1:0] wr_data_in;
    logic [N-1:0]    grant_out;
    logic [1:0]      owner_out;
    logic            busy_out;
    logic            timeout_out;
    logic [DW-1:0]   Q_out;
    logic [DW-1:0]   Qb_out;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Behavioural model state
    bit          m_active;
    int          m_owner;
    int          m_ptr;
    int          m_tenure;
    int          m_cool;
    bit          m_timeout;
    logic [7:0]  m_q;

    shared_reg_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .MAX_HOLD  (MH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_in     (req_in),
        .wr_en_in   (wr_en_in),
        .wr_data_in (wr_data_in),
        .grant_out  (grant_out),
        .owner_out  (owner_out),
        .busy_out   (busy_out),
        .timeout_out(timeout_out),
        .Q_out      (Q_out),
        .Qb_out     (Qb_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_lane(input int lane, input logic [7:0] v);
        wr_data_in[lane*DW +: DW] = v;
    endtask

    task automatic do_reset;
        reset      = 1'b0;
        req_in     = '0;
        wr_en_in   = '0;
        wr_data_in = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset;
        reset      = 1'b0;
        req_in     = 4'b1111;
        wr_en_in   = 4'b1111;
        wr_data_in = $urandom;
        for (int e = 0; e < 5; e++) begin
            tick;
            chk_cnt++;
            if (grant_out !== 4'b0000) $display("FAIL reset_grant: got %b expected 0000", grant_out);
            else pass_cnt++;
            chk_cnt++;
            if (Q_out !== 8'h00 || Qb_out !== 8'hFF)
                $display("FAIL reset_q: got Q=%h Qb=%h expected Q=00 Qb=ff", Q_out, Qb_out);
            else pass_cnt++;
            chk_cnt++;
            if (busy_out !== 1'b0 || timeout_out !== 1'b0 || owner_out !== 2'd0)
                $display("FAIL reset_ctrl: got busy=%b timeout=%b owner=%0d expected 0 0 0",
                         busy_out, timeout_out, owner_out);
            else pass_cnt++;
        end
        req_in   = '0;
        wr_en_in = '0;
        reset    = 1'b1;
    endtask

    task automatic test_single;
        do_reset;
        req_in   = 4'b0100;
        wr_en_in = 4'b0100;
        set_lane(2, 8'hA5);
        tick;
        chk_cnt++;
        if (grant_out !== 4'b0100 || owner_out !== 2'd2 || busy_out !== 1'b1)
            $display("FAIL single_grant: got grant=%b owner=%0d busy=%b expected 0100 2 1",
                     grant_out, owner_out, busy_out);
        else pass_cnt++;
        tick;
        chk_cnt++;
        if (Q_out !== 8'hA5 || Qb_out !== 8'h5A)
            $display("FAIL single_write: got Q=%h Qb=%h expected a5 5a", Q_out, Qb_out);
        else pass_cnt++;
        req_in   = 4'b0000;
        wr_en_in = 4'b0000;
        tick;
        chk_cnt++;
        if (grant_out !== 4'b0000 || busy_out !== 1'b0 || timeout_out !== 1'b0 || owner_out !== 2'd2)
            $display("FAIL single_gap: got grant=%b busy=%b timeout=%b owner=%0d expected 0000 0 0 2",
                     grant_out, busy_out, timeout_out, owner_out);
        else pass_cnt++;
        // Pointer now 3: requester 3 outranks requester 0.
        req_in = 4'b1001;
        tick;
        chk_cnt++;
        if (grant_out !== 4'b0000)
            $display("FAIL single_idle: got grant=%b expected 0000", grant_out);
        else pass_cnt++;
        tick;
        chk_cnt++;
        if (grant_out !== 4'b1000 || owner_out !== 2'd3)
            $display("FAIL single_pointer: got grant=%b owner=%0d expected 1000 3", grant_out, owner_out);
        else pass_cnt++;
        chk_cnt++;
        if (Q_out !== 8'hA5)
            $display("FAIL single_hold_q: got Q=%h expected a5", Q_out);
        else pass_cnt++;
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g;
        do_reset;
        req_in = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int o;
            o = k % 4;
            exp_g = 4'(1 << o);
            tick;
            chk_cnt++;
            if (grant_out !== exp_g || owner_out !== 2'(o))
                $display("FAIL rr_grant%0d: got grant=%b owner=%0d expected %b %0d",
                         k, grant_out, owner_out, exp_g, o);
            else pass_cnt++;
            tick;
            chk_cnt++;
            if (grant_out !== exp_g)
                $display("FAIL rr_hold%0d: got grant=%b expected %b", k, grant_out, exp_g);
            else pass_cnt++;
            req_in[o] = 1'b0;
            tick;
            chk_cnt++;
            if (grant_out !== 4'b0000 || timeout_out !== 1'b0)
                $display("FAIL rr_gap%0d: got grant=%b timeout=%b expected 0000 0", k, grant_out, timeout_out);
            else pass_cnt++;
            req_in[o] = 1'b1;
            tick;
            chk_cnt++;
            if (grant_out !== 4'b0000)
                $display("FAIL rr_idle%0d: got grant=%b expected 0000", k, grant_out);
            else pass_cnt++;
        end
    endtask

    task automatic test_timeout;
        do_reset;
        req_in = 4'b0011;
        tick;
        for (int c = 0; c < int'(MH); c++) begin
            chk_cnt++;
            if (grant_out !== 4'b0001 || timeout_out !== 1'b0)
                $display("FAIL to_tenure%0d: got grant=%b timeout=%b expected 0001 0",
                         c, grant_out, timeout_out);
            else pass_cnt++;
            tick;
        end
        chk_cnt++;
        if (grant_out !== 4'b0000 || timeout_out !== 1'b1)
            $display("FAIL to_pulse: got grant=%b timeout=%b expected 0000 1", grant_out, timeout_out);
        else pass_cnt++;
        tick;
        chk_cnt++;
        if (grant_out !== 4'b0000 || timeout_out !== 1'b0)
            $display("FAIL to_pulse_end: got grant=%b timeout=%b expected 0000 0", grant_out, timeout_out);
        else pass_cnt++;
        tick;
        chk_cnt++;
        if (grant_out !== 4'b0010 || owner_out !== 2'd1)
            $display("FAIL to_next: got grant=%b owner=%0d expected 0010 1", grant_out, owner_out);
        else pass_cnt++;
    endtask

    task automatic test_nonowner_write;
        do_reset;
        req_in   = 4'b0001;
        wr_en_in = 4'b0010;
        set_lane(0, 8'hAA);
        set_lane(1, 8'h3C);
        tick;
        tick;
        chk_cnt++;
        if (Q_out !== 8'h00 || Qb_out !== 8'hFF)
            $display("FAIL nonowner_1: got Q=%h Qb=%h expected 00 ff", Q_out, Qb_out);
        else pass_cnt++;
        tick;
        chk_cnt++;
        if (Q_out !== 8'h00)
            $display("FAIL nonowner_2: got Q=%h expected 00", Q_out);
        else pass_cnt++;
        wr_en_in = 4'b0001;
        tick;
        chk_cnt++;
        if (Q_out !== 8'hAA || Qb_out !== 8'h55)
            $display("FAIL owner_write: got Q=%h Qb=%h expected aa 55", Q_out, Qb_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_grant;
        do_reset;
        req_in   = 4'b1000;
        wr_en_in = 4'b1000;
        set_lane(3, 8'h77);
        tick;
        tick;
        chk_cnt++;
        if (grant_out !== 4'b1000 || Q_out !== 8'h77)
            $display("FAIL midrst_pre: got grant=%b Q=%h expected 1000 77", grant_out, Q_out);
        else pass_cnt++;
        #2 reset = 1'b0;
        #1;
        chk_cnt++;
        if (grant_out !== 4'b0000 || Q_out !== 8'h00 || Qb_out !== 8'hFF || busy_out !== 1'b0)
            $display("FAIL midrst_async: got grant=%b Q=%h Qb=%h busy=%b expected 0000 00 ff 0",
                     grant_out, Q_out, Qb_out, busy_out);
        else pass_cnt++;
        tick;
        req_in   = 4'b0000;
        wr_en_in = 4'b0000;
        reset    = 1'b1;
        tick;
        chk_cnt++;
        if (grant_out !== 4'b0000 || Q_out !== 8'h00)
            $display("FAIL midrst_idle: got grant=%b Q=%h expected 0000 00", grant_out, Q_out);
        else pass_cnt++;
        req_in = 4'b0001;
        tick;
        chk_cnt++;
        if (grant_out !== 4'b0001)
            $display("FAIL midrst_regrant: got grant=%b expected 0001", grant_out);
        else pass_cnt++;
    endtask

    // One clock edge of the behavioural model, using the inputs held at that edge.
    task automatic model_step(input logic [3:0] r, input logic [3:0] w, input logic [31:0] d);
        m_timeout = 1'b0;
        if (m_active) begin
            if (w[m_owner]) m_q = d[m_owner*8 +: 8];
            m_tenure++;
            if (!r[m_owner] || m_tenure == int'(MH)) begin
                m_timeout = r[m_owner];
                m_active  = 1'b0;
                m_ptr     = (m_owner + 1) % 4;
                m_cool    = 1;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (r != 4'b0000) begin
            bit got;
            got = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!got && r[(m_ptr + k) % 4]) begin
                    got     = 1'b1;
                    m_owner = (m_ptr + k) % 4;
                end
            end
            m_active = 1'b1;
            m_tenure = 0;
        end
    endtask

    task automatic test_random;
        logic [3:0] exp_g;
        do_reset;
        m_active = 1'b0; m_owner = 0; m_ptr = 0; m_tenure = 0;
        m_cool = 0; m_timeout = 1'b0; m_q = 8'h00;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) req_in[b] = ~req_in[b];
            wr_en_in   = 4'($urandom);
            wr_data_in = $urandom;
            @(posedge clock);
            model_step(req_in, wr_en_in, wr_data_in);
            #1;
            exp_g = m_active ? 4'(1 << m_owner) : 4'b0000;
            chk_cnt++;
            if (grant_out !== exp_g || owner_out !== 2'(m_owner) ||
                busy_out !== m_active || timeout_out !== m_timeout)
                $display("FAIL rand_ctrl@%0d: got grant=%b owner=%0d busy=%b to=%b expected %b %0d %b %b",
                         c, grant_out, owner_out, busy_out, timeout_out,
                         exp_g, m_owner, m_active, m_timeout);
            else pass_cnt++;
            chk_cnt++;
            if (Q_out !== m_q || Qb_out !== ~m_q)
                $display("FAIL rand_data@%0d: got Q=%h Qb=%h expected %h %h", c, Q_out, Qb_out, m_q, ~m_q);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset      = 1'b0;
        req_in     = '0;
        wr_en_in   = '0;
        wr_data_in = '0;
        test_reset;
        test_single;
        test_round_robin;
        test_timeout;
        test_nonowner_write;
        test_reset_mid_grant;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter that shares one DATA_WIDTH-bit D-flip-flop register (true and complement outputs) among NUM_REQ requesters. Each requester raises a request, receives an exclusive registered grant, writes the shared register while granted, and releases. A hold limit bounds grant tenure so no requester can starve the others. It sits between requesting engines and the shared storage flops as the single write controller.

## Interface
- NUM_REQ, 4: number of requesters; power of two, 2..16.
- DATA_WIDTH, 8: width of the shared register.
- MAX_HOLD, 8: maximum grant tenure in cycles; ≥1.

- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_in  input  NUM_REQ  per-requester request, level.
- wr_en_in  input  NUM_REQ  per-requester write enable.
- wr_data_in  input  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- grant_out  output  NUM_REQ  one-hot grant, registered.
- owner_out  output  log2(NUM_REQ)  index of current/last owner.
- busy_out  output  1  high while in GRANT.
- timeout_out  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.
- Q_out  output  DATA_WIDTH  shared register.
- Qb_out  output  DATA_WIDTH  bitwise complement of Q_out, separately registered.

## Operation
- Reset (reset=0, asynchronous): state IDLE, grant_out=0, owner_out=0, busy_out=0, timeout_out=0, Q_out=0, Qb_out=all ones, priority pointer=0, hold counter=0.
- States: IDLE, GRANT, GAP.
- IDLE: if any req_in bit set, winner = first set bit searching from pointer upward, wrapping modulo NUM_REQ; next state GRANT, grant_out=one-hot(winner), owner_out=winner, hold counter=0. No request: stay IDLE.
- GRANT: busy_out=1. Each cycle, if wr_en_in[owner]=1, then at the clock edge Q_out<=owner data, Qb_out<=~owner data. wr_en_in from non-owners ignored. Hold counter increments per GRANT cycle.
- Release: if req_in[owner]=0 -> GAP. If hold counter reaches MAX_HOLD-1 while req still high -> GAP with timeout_out=1 for the GAP cycle. Write in the final GRANT cycle still takes effect.
- On leaving GRANT: grant_out=0, busy_out=0, pointer<=(owner+1) mod NUM_REQ.
- GAP: one idle cycle; no writes; next state IDLE. Guarantees a grant-free cycle between owners.
- Q_out/Qb_out are only modified in GRANT; otherwise they hold.
- owner_out holds last owner outside GRANT.

## Timing
- req_in sampled in IDLE at edge N -> grant_out visible after edge N (cycle N+1).
- Write: wr_en_in high in a granted cycle -> Q_out/Qb_out updated at the edge ending that cycle (1-cycle latency).
- Request-to-grant minimum latency 1 cycle; back-to-back owners separated by GAP + IDLE decision: new grant earliest 3 cycles after previous owner drops req.
- Tenure: at most MAX_HOLD consecutive GRANT cycles; MAX_HOLD=1 gives single-cycle grants.
- Requester dropping req in the same cycle as its timeout: treated as normal release, timeout_out stays 0.
- Requester re-raising req immediately after release: ranked behind others by pointer.
- Reset asserted mid-GRANT: grant_out and Q_out clear immediately (asynchronously); no partial write.
- Reset deassertion assumed synchronous to clock externally; first decision on first edge after release.

## Test plan
- Reset: reset=0 with wr_en_in/req_in active -> grant_out=0, Q_out=0x00, Qb_out=0xFF, busy_out=0; hold through 5 edges.
- Single requester: req_in=0b0100, wr_en_in[2]=1, data2=0xA5 -> grant_out=0b0100 next cycle, owner_out=2, Q_out=0xA5, Qb_out=0x5A one edge later; drop req -> GAP then IDLE, pointer=3.
- Round-robin fairness: req_in=0b1111 held, each owner drops req after 2 granted cycles -> grant order 0,1,2,3,0 with one GAP cycle between grants.
- Timeout: MAX_HOLD=8, req_in=0b0001 held forever with req_in[1]=1 -> grant0 for exactly 8 cycles, timeout_out=1 for one cycle, then grant_out=0b0010.
- Non-owner write: owner 0 granted with wr_en_in=0b0010, data1=0x3C -> Q_out unchanged.
- Reset mid-grant: owner 3 writing 0x77 each cycle, reset=0 between edges -> grant_out=0, Q_out=0x00, Qb_out=0xFF immediately, state IDLE after release.
